alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control FSM that sequences the 16-bit ALU for one instruction at a time.
- Fetches an instruction word over a req/ack memory port, decodes it and reads the register file.
- Drives the ALU operand and control lines, then writes back the result.
- Maintains the PC and the processor status register (PSR) that holds the ALU flags; executes loads, stores, branches, jumps and JAL.
- Sits between instruction/data memory, the register file and the ALU; it is the only block that drives ALU inputs.

## Interface
- WIDTH, 16, datapath, instruction and address width
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request; held until mem_ack
- mem_ack  in  1  memory completion; ignored when mem_req=0
- mem_addr  out  WIDTH  memory address
- mem_we  out  1  1=write (store), 0=read
- mem_wdata  out  WIDTH  store data
- mem_rdata  in  WIDTH  read data, valid when mem_ack=1
- rf_raddr_a / rf_raddr_b  out  4  register read addresses: Rdest = inst[11:8], Rsrc = inst[3:0]
- rf_rdata_a / rf_rdata_b  in  WIDTH  combinational register read data
- rf_we  out  1  register write strobe
- rf_waddr  out  4  write address
- rf_wdata  out  WIDTH  write data
- alu_src, alu_dst  out  WIDTH  ALU sourceData / destData
- alu_ctl  out  8  ALU operationControl
- alu_en  out  1  ALU enable
- alu_result  in  WIDTH  ALU result
- alu_c, alu_l, alu_f, alu_z, alu_n  in  1  ALU carry, low, overflow, zero, negative
- psr  out  5  registered flags {C,L,F,Z,N}
- pc  out  WIDTH  program counter
- halted  out  1  high in HALT state

## Operation
- Instruction format: op = inst[15:12], Rdest = inst[11:8], ext = inst[7:4], Rsrc = inst[3:0], imm8 = inst[7:0].
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
  - reset forces IDLE; IDLE always goes to FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: IR<=mem_rdata, pc<=pc+1, go to DECODE.
- DECODE (1 cycle) dispatches:
  - op 0000/1000 or I-type: EXECUTE.
  - op 0100 with ext 0000 (LOAD) or 0100 (STORE): MEM.
  - op 0100 with ext 1100 (JCOND) or 1000 (JAL), or op 1100 (BCOND): EXECUTE.
  - Any other encoding: HALT.
- EXECUTE for ALU ops:
  - alu_en=1; alu_ctl = {op, ext} for op 0000/1000, {op, 4'b0000} otherwise.
  - alu_dst = R[Rdest].
  - alu_src = R[Rsrc] for op 0000/1000; otherwise the immediate:
    - sign-extended imm8 for ADDI/SUBI/CMPI;
    - zero-extended imm8 for ADDUI/ANDI/ORI/XORI/MOVI;
    - {8'h00, imm8} for LUI.
  - Latch alu_result into a result register.
  - PSR<=ALU flags only for ADD, ADDU, ADDC, SUB, SUBC, CMP, ADDI, ADDUI, SUBI and CMPI; all other ops leave PSR unchanged.
  - Next state: FETCH for CMP/CMPI, WRITEBACK for everything else.
- ADDC/SUBC: the ALU carry-in is not wired; no correction is applied here.
- WRITEBACK: rf_we=1 for 1 cycle. rf_waddr = Rdest; rf_wdata = result register, or load data for LOAD. Then FETCH.
- MEM:
  - mem_req=1 until mem_ack.
  - LOAD: mem_addr = R[Rsrc]; latch mem_rdata into the result register; then WRITEBACK.
  - STORE: mem_we=1, mem_addr = R[Rsrc], mem_wdata = R[Rdest]; then FETCH.
- Condition codes (Rdest field), evaluated on PSR:
  - 0000 EQ = Z; 0001 NE = !Z; 0010 CS = C; 0011 CC = !C
  - 0100 LO = L; 0101 HS = !L; 0110 LT = N; 0111 GE = !N
  - 1000 FS = F; 1110 UC = 1; all others never taken
- BCOND: if taken, pc<=pc+sext(imm8), using the already-incremented pc. Then FETCH.
- JCOND: if taken, pc<=R[Rsrc]. Then FETCH.
- JAL: uses WRITEBACK to write pc (already incremented) to Rdest, and sets pc<=R[Rsrc] in the same cycle. Then FETCH.
- HALT is sticky until reset; no strobes are asserted.
- Address and PC arithmetic is modulo 2^WIDTH: pc 0xFFFF + 1 = 0x0000.

## Timing
- Reset values: state=IDLE, pc=0, IR=0, result register=0, psr=0, halted=0.
- All strobes (mem_req, mem_we, rf_we, alu_en) are 0 in IDLE, DECODE and HALT, and are decoded from registered state only.
- Latency with a zero-wait memory (mem_ack in the first FETCH/MEM cycle):
  - ALU op: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - CMP/CMPI, branch, JCOND: 3 cycles.
  - JAL and LOAD: 4 cycles; STORE: 3 cycles.
  - Each memory wait cycle adds 1.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1. The transfer completes on the edge where mem_req and mem_ack are both 1. mem_req deasserts the following cycle unless the next state also requests.
- Reset mid-transfer: mem_req and rf_we drop immediately (asynchronously); no partial writeback and no PSR update.
- Flags written in EXECUTE are visible to a branch in the very next instruction.

## Test plan
- Reset, then memory returns ADD R1,R2 (0x0152) with R1=3, R2=4, ack on the first cycle -> alu_ctl=0x05, rf_we with rf_waddr=1 and rf_wdata=7 in cycle 4, pc=1.
- CMPI R1,#5 with R1=5, followed by BEQ +3 (0xC003) -> psr Z=1, no rf_we, pc goes 1 to 2 to 5; with R1=6 the branch is not taken and pc=3.
- LOAD R3,[R4] with R4=0x0100, ack delayed 3 cycles -> mem_addr=0x0100 held for 4 cycles, R3=mem_rdata, total 7 cycles.
- STORE R5 to [R6] -> mem_we=1, mem_addr=R6, mem_wdata=R5, no rf_we; JAL R14,R7 with R7=0x0040 at pc=9 -> R14=0x000A, pc=0x0040.
- Illegal opcode 0x7000 -> halted=1 with strobes quiet for 20 cycles; assert reset mid-LOAD -> mem_req falls immediately, pc=0, restart from FETCH.

Source files
------------

// File: rtl/alu_sequencer.sv
//-----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle control FSM that runs one instruction at a time through the
// 16-bit ALU. It fetches an instruction over a req/ack memory port, decodes
// it, reads the register file, drives the ALU, writes the result back, and
// also executes loads, stores, conditional branches, conditional jumps and
// JAL. It owns the program counter and the processor status register (PSR).
//
// Instruction fields: op = inst[15:12], Rdest = inst[11:8],
//                     ext = inst[7:4],  Rsrc = inst[3:0], imm8 = inst[7:0].
//
// Ports
//   clk, reset               system clock; asynchronous active-high reset
//   mem_req/mem_ack          memory handshake; req held until ack
//   mem_addr/mem_we          memory address and write select
//   mem_wdata/mem_rdata      store data / read data (valid with mem_ack)
//   rf_raddr_a/rf_raddr_b    register read addresses (Rdest / Rsrc)
//   rf_rdata_a/rf_rdata_b    combinational register read data
//   rf_we/rf_waddr/rf_wdata  register write port
//   alu_src/alu_dst          ALU sourceData / destData
//   alu_ctl/alu_en           ALU operationControl / enable
//   alu_result, alu_c..n     ALU result and flags {C,L,F,Z,N}
//   psr                      registered flags {C,L,F,Z,N}
//   pc                       program counter
//   halted                   high while the FSM sits in HALT
//-----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    // memory port
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    // register file
    output logic [3:0]       rf_raddr_a,
    output logic [3:0]       rf_raddr_b,
    input  logic [WIDTH-1:0] rf_rdata_a,
    input  logic [WIDTH-1:0] rf_rdata_b,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    // ALU
    output logic [WIDTH-1:0] alu_src,
    output logic [WIDTH-1:0] alu_dst,
    output logic [7:0]       alu_ctl,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_l,
    input  logic             alu_f,
    input  logic             alu_z,
    input  logic             alu_n,
    // status
    output logic [4:0]       psr,
    output logic [WIDTH-1:0] pc,
    output logic             halted
);

    // FSM encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    // Major opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // ext field for op 0100
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STORE = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    // ext field for op 0000 (flag-setting subset)
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_SUBC = 4'b1010;
    localparam logic [3:0] EXT_CMP  = 4'b1011;

    // PSR bit positions within {C,L,F,Z,N}
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    logic [2:0]       state;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       psr_q;
    logic [WIDTH-1:0] pc_q;

    // Instruction fields, always taken from the registered IR
    logic [3:0] op;
    logic [3:0] rdest;
    logic [3:0] ext;
    logic [3:0] rsrc;
    logic [7:0] imm8;

    assign op    = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign rsrc  = ir[3:0];
    assign imm8  = ir[7:0];

    // Decoded instruction class
    logic             is_rtype;
    logic             is_itype;
    logic             is_alu;
    logic             is_load;
    logic             is_store;
    logic             is_jal;
    logic             is_jcond;
    logic             is_bcond;
    logic             is_cmp;
    logic             sets_flags;
    logic             cond_true;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] imm_ext;

    assign imm_sext = {{(WIDTH-8){imm8[7]}}, imm8};
    assign imm_zext = {{(WIDTH-8){1'b0}}, imm8};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        is_itype   = 1'b0;
        sets_flags = 1'b0;
        imm_ext    = imm_zext;

        is_rtype = (op == OP_RTYPE) || (op == OP_SHIFT);
        is_load  = (op == OP_MEMJ) && (ext == EXT_LOAD);
        is_store = (op == OP_MEMJ) && (ext == EXT_STORE);
        is_jal   = (op == OP_MEMJ) && (ext == EXT_JAL);
        is_jcond = (op == OP_MEMJ) && (ext == EXT_JCOND);
        is_bcond = (op == OP_BCOND);
        is_cmp   = ((op == OP_RTYPE) && (ext == EXT_CMP)) || (op == OP_CMPI);

        case (op)
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_MOVI: is_itype = 1'b1;
            // LUI hands the ALU the raw byte in the low half; the ALU shifts it.
            OP_LUI:                                     is_itype = 1'b1;
            OP_ADDI, OP_SUBI, OP_CMPI: begin
                is_itype = 1'b1;
                imm_ext  = imm_sext;
            end
            default: ;
        endcase

        is_alu = is_rtype || is_itype;

        if (op == OP_RTYPE) begin
            case (ext)
                EXT_ADD, EXT_ADDU, EXT_ADDC,
                EXT_SUB, EXT_SUBC, EXT_CMP: sets_flags = 1'b1;
                default:                    sets_flags = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDUI,
                OP_SUBI, OP_CMPI: sets_flags = 1'b1;
                default:          sets_flags = 1'b0;
            endcase
        end
    end

    // Condition code lives in the Rdest field and is tested against the PSR.
    always_comb begin
        case (rdest)
            4'b0000: cond_true =  psr_q[PSR_Z];
            4'b0001: cond_true = !psr_q[PSR_Z];
            4'b0010: cond_true =  psr_q[PSR_C];
            4'b0011: cond_true = !psr_q[PSR_C];
            4'b0100: cond_true =  psr_q[PSR_L];
            4'b0101: cond_true = !psr_q[PSR_L];
            4'b0110: cond_true =  psr_q[PSR_N];
            4'b0111: cond_true = !psr_q[PSR_N];
            4'b1000: cond_true =  psr_q[PSR_F];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // State, IR, PC, PSR and result register
    // NOTE: the reset clears only these few control registers; there is no storage array to clear here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ir       <= '0;
            result_q <= '0;
            psr_q    <= '0;
            pc_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: state <= S_FETCH;

                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc_q  <= pc_q + WIDTH'(1);
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (is_alu || is_bcond || is_jcond || is_jal)
                        state <= S_EXECUTE;
                    else if (is_load || is_store)
                        state <= S_MEM;
                    else
                        state <= S_HALT;
                end

                S_EXECUTE: begin
                    if (is_alu) begin
                        result_q <= alu_result;
                        if (sets_flags)
                            psr_q <= {alu_c, alu_l, alu_f, alu_z, alu_n};
                        // Compares only update flags; there is nothing to write back.
                        state <= is_cmp ? S_FETCH : S_WRITEBACK;
                    end else if (is_bcond) begin
                        // pc already points past the branch, so the offset is from pc+1.
                        if (cond_true)
                            pc_q <= pc_q + imm_sext;
                        state <= S_FETCH;
                    end else if (is_jcond) begin
                        if (cond_true)
                            pc_q <= rf_rdata_b;
                        state <= S_FETCH;
                    end else if (is_jal) begin
                        state <= S_WRITEBACK;
                    end else begin
                        state <= S_HALT;
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        if (is_load) begin
                            result_q <= mem_rdata;
                            state    <= S_WRITEBACK;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end

                S_WRITEBACK: begin
                    // JAL writes the return address and redirects in the same cycle.
                    if (is_jal)
                        pc_q <= rf_rdata_b;
                    state <= S_FETCH;
                end

                S_HALT: state <= S_HALT;

                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state, so a reset drops every
    // strobe as soon as it asserts.
    assign mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign mem_we    = (state == S_MEM) && is_store;
    assign mem_addr  = (state == S_FETCH) ? pc_q : rf_rdata_b;
    assign mem_wdata = rf_rdata_a;

    assign rf_raddr_a = rdest;
    assign rf_raddr_b = rsrc;
    assign rf_we      = (state == S_WRITEBACK);
    assign rf_waddr   = rdest;
    assign rf_wdata   = is_jal ? pc_q : result_q;

    assign alu_en  = (state == S_EXECUTE) && is_alu;
    assign alu_ctl = is_rtype ? {op, ext} : {op, 4'b0000};
    assign alu_dst = rf_rdata_a;
    assign alu_src = is_rtype ? rf_rdata_b : imm_ext;

    assign psr    = psr_q;
    assign pc     = pc_q;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
//-----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Directed bench for alu_sequencer. Provides a word-addressed memory with a
// programmable ack delay, a static register file and a small ALU covering
// ADD/ADDI and CMP/CMPI. Expected values are hand-computed constants.
//-----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_src;
    logic [15:0] alu_dst;
    logic [7:0]  alu_ctl;
    logic        alu_en;
    logic [15:0] alu_result;
    logic        alu_c;
    logic        alu_l;
    logic        alu_f;
    logic        alu_z;
    logic        alu_n;
    logic [4:0]  psr;
    logic [15:0] pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];
    logic [15:0] rf  [0:15];
    int          ack_delay;
    int          wait_cnt;
    logic [16:0] sum17;

    alu_sequencer #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (rst),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .alu_src    (alu_src),
        .alu_dst    (alu_dst),
        .alu_ctl    (alu_ctl),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_l      (alu_l),
        .alu_f      (alu_f),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .psr        (psr),
        .pc         (pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack after ack_delay wait cycles of a held request
    assign mem_rdata = mem[mem_addr[9:0]];
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 0;
        else if (mem_req && mem_ack)
            wait_cnt <= 0;
        else if (mem_req)
            wait_cnt <= wait_cnt + 1;
    end

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    // Reference ALU: ADD/ADDI and CMP/CMPI, anything else passes src through
    always_comb begin
        sum17      = 17'd0;
        alu_result = alu_src;
        {alu_c, alu_l, alu_f, alu_z, alu_n} = 5'b00000;
        case (alu_ctl)
            8'h05, 8'h50: begin
                sum17      = {1'b0, alu_dst} + {1'b0, alu_src};
                alu_result = sum17[15:0];
                alu_c      = sum17[16];
                alu_z      = (sum17[15:0] == 16'h0000);
                alu_n      = sum17[15];
            end
            8'h0B, 8'hB0: begin
                alu_z = (alu_dst == alu_src);
                alu_l = (alu_dst < alu_src);
                alu_n = ($signed(alu_dst) < $signed(alu_src));
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, then releases it; the DUT is in IDLE afterwards.
    task automatic do_reset();
        rst       = 1'b1;
        ack_delay = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ack_delay = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++)   rf[i]  = 16'h0000;

        // ---- ADD R1,R2 then ADDI R2,#-2 ----
        mem[0] = 16'h0152;
        mem[1] = 16'h52FE;
        rf[1]  = 16'h0003;
        rf[2]  = 16'h0004;
        do_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_psr", {11'd0, psr}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        check("rst_strobes", {12'd0, mem_req, mem_we, rf_we, alu_en}, 16'h0000);
        step(); // FETCH
        check("add_fetch_req", {15'd0, mem_req}, 16'h0001);
        check("add_fetch_addr", mem_addr, 16'h0000);
        step(); // DECODE
        check("add_decode_pc", pc, 16'h0001);
        check("add_decode_strobes", {12'd0, mem_req, mem_we, rf_we, alu_en}, 16'h0000);
        step(); // EXECUTE
        check("add_alu_en", {15'd0, alu_en}, 16'h0001);
        check("add_alu_ctl", {8'd0, alu_ctl}, 16'h0005);
        check("add_alu_dst", alu_dst, 16'h0003);
        check("add_alu_src", alu_src, 16'h0004);
        step(); // WRITEBACK
        check("add_rf_we", {15'd0, rf_we}, 16'h0001);
        check("add_rf_waddr", {12'd0, rf_waddr}, 16'h0001);
        check("add_rf_wdata", rf_wdata, 16'h0007);
        check("add_psr", {11'd0, psr}, 16'h0000);
        step(); // FETCH next
        check("add_next_fetch", mem_addr, 16'h0001);
        check("add_rf_we_drop", {15'd0, rf_we}, 16'h0000);
        step(); // DECODE
        step(); // EXECUTE ADDI
        check("addi_alu_ctl", {8'd0, alu_ctl}, 16'h0050);
        check("addi_sext_src", alu_src, 16'hFFFE);
        step(); // WRITEBACK
        check("addi_rf_wdata", rf_wdata, 16'h0002);
        check("addi_rf_waddr", {12'd0, rf_waddr}, 16'h0002);
        check("addi_psr_carry", {11'd0, psr}, 16'h0010);

        // ---- CMPI R1,#5 ; BEQ +3 (taken) ----
        mem[0] = 16'hB105;
        mem[1] = 16'hC003;
        rf[1]  = 16'h0005;
        do_reset();
        step(); // FETCH
        step(); // DECODE
        step(); // EXECUTE
        check("cmpi_alu_ctl", {8'd0, alu_ctl}, 16'h00B0);
        check("cmpi_alu_src", alu_src, 16'h0005);
        step(); // FETCH (no writeback for compares)
        check("cmpi_psr_z", {11'd0, psr}, 16'h0002);
        check("cmpi_no_rf_we", {15'd0, rf_we}, 16'h0000);
        check("cmpi_fetch_addr", mem_addr, 16'h0001);
        step(); // DECODE
        check("beq_decode_pc", pc, 16'h0002);
        step(); // EXECUTE branch
        check("beq_alu_en", {15'd0, alu_en}, 16'h0000);
        step(); // FETCH at target
        check("beq_taken_pc", pc, 16'h0005);
        check("beq_taken_addr", mem_addr, 16'h0005);

        // ---- CMPI R1,#5 with R1=6 ; BEQ not taken ----
        rf[1] = 16'h0006;
        do_reset();
        step(); step(); step(); // FETCH DECODE EXECUTE
        step(); // FETCH BEQ
        check("cmpi_ne_psr", {11'd0, psr}, 16'h0000);
        step(); step(); // DECODE EXECUTE
        step(); // FETCH fall-through
        check("beq_nt_addr", mem_addr, 16'h0002);
        step(); // DECODE
        check("beq_nt_pc", pc, 16'h0003);

        // ---- LOAD R3,[R4], ack after 3 wait cycles ----
        mem[0]     = 16'h4304;
        mem[16'h100] = 16'hBEEF;
        rf[4]      = 16'h0100;
        do_reset();
        step(); // FETCH
        step(); // DECODE
        ack_delay = 3;
        for (int i = 0; i < 4; i++) begin
            step(); // MEM
            check("load_mem_req", {15'd0, mem_req}, 16'h0001);
            check("load_mem_addr", mem_addr, 16'h0100);
            check("load_mem_we", {15'd0, mem_we}, 16'h0000);
        end
        step(); // WRITEBACK, 7th cycle
        check("load_rf_we", {15'd0, rf_we}, 16'h0001);
        check("load_rf_waddr", {12'd0, rf_waddr}, 16'h0003);
        check("load_rf_wdata", rf_wdata, 16'hBEEF);
        check("load_req_drop", {15'd0, mem_req}, 16'h0000);
        ack_delay = 0;

        // ---- STORE R5 -> [R6]; BUC +7; JAL R14,R7 at pc 9 ----
        mem[0] = 16'h4546;
        mem[1] = 16'hCE07;
        mem[9] = 16'h4E87;
        rf[5]  = 16'h1234;
        rf[6]  = 16'h0200;
        rf[7]  = 16'h0040;
        do_reset();
        step(); // FETCH
        step(); // DECODE
        step(); // MEM
        check("store_mem_we", {15'd0, mem_we}, 16'h0001);
        check("store_mem_addr", mem_addr, 16'h0200);
        check("store_mem_wdata", mem_wdata, 16'h1234);
        check("store_no_rf_we", {15'd0, rf_we}, 16'h0000);
        step(); // FETCH (store done in 3 cycles)
        check("store_next_fetch", mem_addr, 16'h0001);
        check("store_we_drop", {15'd0, mem_we}, 16'h0000);
        step(); step(); // DECODE EXECUTE (BUC)
        step(); // FETCH at 9
        check("buc_pc", pc, 16'h0009);
        step(); // DECODE
        step(); // EXECUTE
        step(); // WRITEBACK
        check("jal_rf_we", {15'd0, rf_we}, 16'h0001);
        check("jal_rf_waddr", {12'd0, rf_waddr}, 16'h000E);
        check("jal_rf_wdata", rf_wdata, 16'h000A);
        step(); // FETCH at target
        check("jal_pc", pc, 16'h0040);
        check("jal_fetch_addr", mem_addr, 16'h0040);

        // ---- Illegal opcode halts ----
        mem[0] = 16'h7000;
        do_reset();
        step(); step(); // FETCH DECODE
        step(); // HALT
        check("halt_flag", {15'd0, halted}, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_quiet", {11'd0, mem_req, mem_we, rf_we, alu_en, halted}, 16'h0001);
        end
        check("halt_pc", pc, 16'h0001);

        // ---- Reset in the middle of a LOAD ----
        mem[0] = 16'h4304;
        do_reset();
        check("rst_clears_halt", {15'd0, halted}, 16'h0000);
        step(); // FETCH
        step(); // DECODE
        ack_delay = 10;
        step(); // MEM, waiting
        check("midload_req", {15'd0, mem_req}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("midload_req_drop", {15'd0, mem_req}, 16'h0000);
        check("midload_rf_we", {15'd0, rf_we}, 16'h0000);
        check("midload_pc", pc, 16'h0000);
        step();
        ack_delay = 0;
        rst = 1'b0;
        step(); // FETCH again
        check("restart_req", {15'd0, mem_req}, 16'h0001);
        check("restart_addr", mem_addr, 16'h0000);
        check("restart_psr", {11'd0, psr}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
